memory_access: RTL and testbench
================================

// Module: memory_access
// PURPOSE
//  EX/MEM boundary and memory stage of the LEGv8 datapath. Registers the outputs of execute
//  (aluResult_E, writeData_E, PCBranch_E, zero_E) together with their memory/branch controls.
//  Runs loads/stores against a data memory over a req/ack handshake and stalls upstream while
//  an access is outstanding. Produces the PCSrc decision and the write-back operands.
// PARAMETERS
//  N        64  datapath width (address, data, PC)
//  TIMEOUT  15  max cycles dm_req waits for dm_ack before the access is aborted (>=1)
// PORTS
//  clk         in   1  clock, rising edge
//  reset       in   1  asynchronous, active-low reset
//  valid_E     in   1  execute presents a valid instruction this cycle
//  MemRead_E   in   1  instruction is a load (LDUR)
//  MemWrite_E  in   1  instruction is a store (STUR)
//  Branch_E    in   1  instruction is CBZ/B
//  zero_E      in   1  ALU zero flag
//  aluResult_E in   N  effective address / ALU result
//  writeData_E in   N  store data
//  PCBranch_E  in   N  branch target
//  stall_M     out  1  upstream must hold its inputs; instruction not accepted
//  dm_req      out  1  data-memory request, held high until ack or abort
//  dm_we       out  1  1 = write, 0 = read; valid while dm_req
//  dm_addr     out  N  data-memory address; stable while dm_req
//  dm_wdata    out  N  data-memory write data; stable while dm_req
//  dm_ack      in   1  memory completes the request this cycle
//  dm_rdata    in   N  read data; valid when dm_ack && !dm_we
//  valid_M     out  1  result registers hold a completed instruction (1-cycle pulse)
//  PCSrc_M     out  1  Branch & zero of the completed instruction; 0 when !valid_M
//  PCBranch_M  out  N  registered branch target
//  aluResult_M out  N  registered ALU result
//  readData_M  out  N  load data; 0 for non-loads and on error
//  memErr_M    out  1  completed instruction faulted (timeout/misaligned/illegal); with valid_M only
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, timeout counter 0. Reset asserted mid-ACCESS drops dm_req
//    immediately; the transaction is abandoned, with no completion reported.
//  Accept = valid_E && !stall_M. stall_M = (state==ACCESS), registered.
//  FSM IDLE:
//    accept, no memory op -> capture; valid_M=1 next cycle; stay IDLE.
//    accept, MemRead xor MemWrite, aluResult_E[2:0]==0 -> capture; ACCESS; dm_req=1 next cycle.
//    accept, misaligned addr ([2:0]!=0) or MemRead&MemWrite -> no dm_req;
//      valid_M=1, memErr_M=1 next cycle.
//    dm_ack while IDLE is ignored.
//  FSM ACCESS: dm_req=1, dm_we/addr/wdata constant; counter increments each cycle without ack.
//    dm_ack -> latch dm_rdata (reads only); IDLE; valid_M=1 next cycle; dm_req low next cycle.
//    counter reaches TIMEOUT without ack -> IDLE; valid_M=1, memErr_M=1, readData_M=0 next cycle.
//    ack on the same cycle as timeout: ack wins, no error.
//  Latency: non-memory op: 1 cycle accept->valid_M. Memory op: ack in cycle k -> valid_M in k+1.
//    Minimum 2 cycles accept->valid_M. The cycle after completion, stall_M=0 and a new accept
//    is allowed while valid_M is high.
//  valid_M is high for exactly one cycle per accepted instruction. aluResult_M/PCBranch_M hold
//    their captured values until the next accept.
//  PCSrc_M = registered(Branch_E & zero_E) gated by valid_M. Branches never access memory.
// TESTING
//  1 Reset low mid-stream -> all outputs 0; release, valid_E=0 -> valid_M stays 0.
//  2 ADD: valid_E=1, aluResult_E=0x2A -> next cycle valid_M=1, aluResult_M=0x2A, readData_M=0, stall_M=0.
//  3 LDUR addr 0x10, ack 3 cycles after dm_req with rdata 0xDEAD -> stall_M high 4 cycles,
//    valid_M=1, readData_M=0xDEAD.
//  4 STUR addr 0x8, data 0x55, no ack -> dm_req high TIMEOUT cycles, then valid_M=1, memErr_M=1,
//    dm_req=0.
//  5 LDUR addr 0x0C (misaligned) -> no dm_req; next cycle valid_M=1, memErr_M=1.
//  6 CBZ zero_E=1, PCBranch_E=0x40 -> PCSrc_M=1, PCBranch_M=0x40; zero_E=0 -> PCSrc_M=0.

Source files
------------

// File: rtl/memory_access.sv
// EX/MEM pipeline boundary and memory stage: captures execute results, runs loads/stores over a
// req/ack data-memory handshake with timeout, and presents write-back and branch-decision operands.
module memory_access #(
  parameter int unsigned N       = 64,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         valid_E,
  input  logic         MemRead_E,
  input  logic         MemWrite_E,
  input  logic         Branch_E,
  input  logic         zero_E,
  input  logic [N-1:0] aluResult_E,
  input  logic [N-1:0] writeData_E,
  input  logic [N-1:0] PCBranch_E,
  output logic         stall_M,
  output logic         dm_req,
  output logic         dm_we,
  output logic [N-1:0] dm_addr,
  output logic [N-1:0] dm_wdata,
  input  logic         dm_ack,
  input  logic [N-1:0] dm_rdata,
  output logic         valid_M,
  output logic         PCSrc_M,
  output logic [N-1:0] PCBranch_M,
  output logic [N-1:0] aluResult_M,
  output logic [N-1:0] readData_M,
  output logic         memErr_M
);

  // Counter only needs to reach TIMEOUT-1; the abort fires on that cycle.
  localparam int unsigned CntW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  typedef enum logic [0:0] {StIdle, StAccess} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            valid_q, valid_d;
  logic            err_q, err_d;
  logic            pcsrc_q, pcsrc_d;
  logic            we_q, we_d;
  logic [N-1:0]    addr_q, addr_d;
  logic [N-1:0]    wdata_q, wdata_d;
  logic [N-1:0]    alu_q, alu_d;
  logic [N-1:0]    pcb_q, pcb_d;
  logic [N-1:0]    rdata_q, rdata_d;

  logic mem_rd, mem_wr, misaligned;

  // Branches never touch memory, so their memory controls are masked.
  assign mem_rd     = MemRead_E & ~Branch_E;
  assign mem_wr     = MemWrite_E & ~Branch_E;
  assign misaligned = (aluResult_E[2:0] != 3'b000);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    pcsrc_d = pcsrc_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    alu_d   = alu_q;
    pcb_d   = pcb_q;
    rdata_d = rdata_q;

    unique case (state_q)
      StIdle: begin
        if (valid_E) begin
          alu_d   = aluResult_E;
          pcb_d   = PCBranch_E;
          pcsrc_d = Branch_E & zero_E;
          rdata_d = '0;
          if (mem_rd | mem_wr) begin
            if ((mem_rd & mem_wr) | misaligned) begin
              valid_d = 1'b1;
              err_d   = 1'b1;
            end else begin
              state_d = StAccess;
              cnt_d   = '0;
              we_d    = mem_wr;
              addr_d  = aluResult_E;
              wdata_d = writeData_E;
            end
          end else begin
            valid_d = 1'b1;
          end
        end
      end
      StAccess: begin
        // An ack on the timeout cycle still completes the access normally.
        if (dm_ack) begin
          state_d = StIdle;
          valid_d = 1'b1;
          if (!we_q) rdata_d = dm_rdata;
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          state_d = StIdle;
          valid_d = 1'b1;
          err_d   = 1'b1;
          rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      pcsrc_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      alu_q   <= '0;
      pcb_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      pcsrc_q <= pcsrc_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      alu_q   <= alu_d;
      pcb_q   <= pcb_d;
      rdata_q <= rdata_d;
    end
  end

  assign stall_M     = (state_q == StAccess);
  assign dm_req      = (state_q == StAccess);
  assign dm_we       = we_q;
  assign dm_addr     = addr_q;
  assign dm_wdata    = wdata_q;
  assign valid_M     = valid_q;
  assign PCSrc_M     = pcsrc_q & valid_q;
  assign PCBranch_M  = pcb_q;
  assign aluResult_M = alu_q;
  assign readData_M  = rdata_q;
  assign memErr_M    = err_q & valid_q;

endmodule

// File: tb/tb_memory_access.sv
// Scoreboard bench for memory_access: stimulus pushes expected completions, a monitor pops them
// whenever valid_M is seen on the falling edge.
module tb_memory_access;

  localparam int unsigned N       = 64;
  localparam int unsigned TIMEOUT = 15;

  logic         clk = 1'b0;
  logic         reset;
  logic         valid_E, MemRead_E, MemWrite_E, Branch_E, zero_E;
  logic [N-1:0] aluResult_E, writeData_E, PCBranch_E;
  logic         stall_M, dm_req, dm_we, dm_ack;
  logic [N-1:0] dm_addr, dm_wdata, dm_rdata;
  logic         valid_M, PCSrc_M, memErr_M;
  logic [N-1:0] PCBranch_M, aluResult_M, readData_M;

  always #5 clk = ~clk;

  memory_access #(.N(N), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .valid_E    (valid_E),
    .MemRead_E  (MemRead_E),
    .MemWrite_E (MemWrite_E),
    .Branch_E   (Branch_E),
    .zero_E     (zero_E),
    .aluResult_E(aluResult_E),
    .writeData_E(writeData_E),
    .PCBranch_E (PCBranch_E),
    .stall_M    (stall_M),
    .dm_req     (dm_req),
    .dm_we      (dm_we),
    .dm_addr    (dm_addr),
    .dm_wdata   (dm_wdata),
    .dm_ack     (dm_ack),
    .dm_rdata   (dm_rdata),
    .valid_M    (valid_M),
    .PCSrc_M    (PCSrc_M),
    .PCBranch_M (PCBranch_M),
    .aluResult_M(aluResult_M),
    .readData_M (readData_M),
    .memErr_M   (memErr_M)
  );

  typedef struct packed {
    logic [N-1:0] alu;
    logic [N-1:0] pcb;
    logic [N-1:0] rd;
    logic         err;
    logic         pcsrc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every valid_M must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset === 1'b1 && valid_M === 1'b1) begin
      exp_t act, e;
      act = '{alu: aluResult_M, pcb: PCBranch_M, rd: readData_M, err: memErr_M, pcsrc: PCSrc_M};
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_valid_M: got alu=%0h with no completion outstanding",
                 aluResult_M);
      end else begin
        e = exp_q.pop_front();
        if (act !== e) begin
          n_fail++;
          $display("FAIL completion: got alu=%0h pcb=%0h rd=%0h err=%0b pcsrc=%0b expected alu=%0h pcb=%0h rd=%0h err=%0b pcsrc=%0b",
                   act.alu, act.pcb, act.rd, act.err, act.pcsrc,
                   e.alu, e.pcb, e.rd, e.err, e.pcsrc);
        end
      end
    end
  end

  // Presents one instruction for one clock edge; optionally records its expected completion.
  task automatic issue(input logic rd, input logic wr, input logic br, input logic z,
                       input logic [N-1:0] alu, input logic [N-1:0] wd, input logic [N-1:0] pcb,
                       input logic push, input logic [N-1:0] exp_rd, input logic exp_err,
                       input logic exp_pcsrc);
    valid_E     = 1'b1;
    MemRead_E   = rd;
    MemWrite_E  = wr;
    Branch_E    = br;
    zero_E      = z;
    aluResult_E = alu;
    writeData_E = wd;
    PCBranch_E  = pcb;
    if (push) exp_q.push_back('{alu: alu, pcb: pcb, rd: exp_rd, err: exp_err, pcsrc: exp_pcsrc});
    @(posedge clk);
    #1;
    valid_E    = 1'b0;
    MemRead_E  = 1'b0;
    MemWrite_E = 1'b0;
    Branch_E   = 1'b0;
    zero_E     = 1'b0;
  endtask

  // Memory responder for one access: acks in cycle ack_cycle after accept (0 = never).
  task automatic run_access(input int ack_cycle, input logic [N-1:0] rdata,
                            input logic exp_we, input logic [N-1:0] exp_addr,
                            input logic [N-1:0] exp_wdata,
                            output int stall_cnt, output int req_cnt);
    bit done = 0;
    stall_cnt = 0;
    req_cnt   = 0;
    for (int c = 1; c <= 40 && !done; c++) begin
      @(negedge clk);
      if (c == 1) begin
        check("dm_we", dm_we, exp_we);
        check("dm_addr", dm_addr, exp_addr);
        if (exp_we) check("dm_wdata", dm_wdata, exp_wdata);
      end
      if (!stall_M) begin
        dm_ack = 1'b0;
        check("dm_req_after", dm_req, 1'b0);
        done = 1;
      end else begin
        stall_cnt++;
        if (dm_req) req_cnt++;
        dm_ack   = (c == ack_cycle);
        dm_rdata = rdata;
      end
    end
    dm_ack = 1'b0;
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL access_bound: got stall_M still high expected completion within 40 cycles");
    end
  endtask

  int sc, rc;

  initial begin
    reset       = 1'b0;
    valid_E     = 1'b0;
    MemRead_E   = 1'b0;
    MemWrite_E  = 1'b0;
    Branch_E    = 1'b0;
    zero_E      = 1'b0;
    aluResult_E = '0;
    writeData_E = '0;
    PCBranch_E  = '0;
    dm_ack      = 1'b0;
    dm_rdata    = '0;

    #2;
    check("reset_ctrl", {stall_M, dm_req, dm_we, valid_M, PCSrc_M, memErr_M}, 0);
    check("reset_bus", dm_addr | dm_wdata | PCBranch_M | aluResult_M | readData_M, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // Reset asserted during an outstanding load abandons it.
    issue(0, 0, 0, 0, 64'h11, 0, 0, 1, 0, 0, 0);
    issue(1, 0, 0, 0, 64'h10, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("req_before_reset", dm_req, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midreset_ctrl", {stall_M, dm_req, dm_we, valid_M, PCSrc_M, memErr_M}, 0);
    check("midreset_bus", dm_addr | dm_wdata | PCBranch_M | aluResult_M | readData_M, 0);
    @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    repeat (3) begin
      @(negedge clk);
      check("idle_valid_M", valid_M, 1'b0);
    end
    @(posedge clk);
    #1;

    // ADD, then back-to-back ADDs while valid_M is high.
    issue(0, 0, 0, 0, 64'h2A, 0, 0, 1, 0, 0, 0);
    @(negedge clk);
    check("add_stall", stall_M, 1'b0);
    check("add_valid", valid_M, 1'b1);
    @(posedge clk);
    #1;
    issue(0, 0, 0, 0, 64'h100, 0, 64'h7, 1, 0, 0, 0);
    issue(0, 0, 0, 0, 64'h200, 0, 64'h9, 1, 0, 0, 0);

    // LDUR acked 3 cycles after dm_req rises.
    issue(1, 0, 0, 0, 64'h10, 0, 0, 1, 64'hDEAD, 0, 0);
    run_access(4, 64'hDEAD, 1'b0, 64'h10, 0, sc, rc);
    check("ldur_stall_cycles", sc, 4);
    check("ldur_req_cycles", rc, 4);

    // STUR with no ack times out; new accept right in the completion cycle.
    issue(0, 1, 0, 0, 64'h8, 64'h55, 0, 1, 0, 1, 0);
    run_access(0, 64'hFFFF, 1'b1, 64'h8, 64'h55, sc, rc);
    check("stur_req_cycles", rc, TIMEOUT);
    check("stur_stall_cycles", sc, TIMEOUT);

    // Ack on the very timeout cycle completes without error.
    issue(1, 0, 0, 0, 64'h18, 0, 0, 1, 64'hBEEF, 0, 0);
    run_access(TIMEOUT, 64'hBEEF, 1'b0, 64'h18, 0, sc, rc);
    check("edge_req_cycles", rc, TIMEOUT);

    // Misaligned load and read+write conflict fault without touching memory.
    issue(1, 0, 0, 0, 64'h0C, 0, 0, 1, 0, 1, 0);
    @(negedge clk);
    check("misaligned_req", dm_req, 1'b0);
    check("misaligned_stall", stall_M, 1'b0);
    @(posedge clk);
    #1;
    issue(1, 1, 0, 0, 64'h20, 64'h3, 0, 1, 0, 1, 0);
    @(negedge clk);
    check("rdwr_req", dm_req, 1'b0);

    // Stray ack while idle must not complete anything.
    dm_ack = 1'b1;
    @(negedge clk);
    dm_ack = 1'b0;
    @(negedge clk);
    check("idle_ack_valid", valid_M, 1'b0);
    check("idle_ack_req", dm_req, 1'b0);
    @(posedge clk);
    #1;

    // CBZ taken and not taken.
    issue(0, 0, 1, 1, 64'h0, 0, 64'h40, 1, 0, 0, 1);
    @(negedge clk);
    check("cbz_taken_pcsrc", PCSrc_M, 1'b1);
    check("cbz_pcbranch", PCBranch_M, 64'h40);
    @(posedge clk);
    #1;
    issue(0, 0, 1, 0, 64'h5, 0, 64'h80, 1, 0, 0, 0);
    @(negedge clk);
    check("cbz_not_taken_pcsrc", PCSrc_M, 1'b0);
    @(negedge clk);
    check("pcsrc_gated", PCSrc_M, 1'b0);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
